// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The IF/ID bundle type is also consumed by the decode stage.
package if_fetch_unit_pkg;

   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
      logic        valid;
   } ifid_t;

   function automatic ifid_t make_bubble(input logic [31:0] nop);
      ifid_t b;
      b.instr = nop;
      b.npc   = 32'h0;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and
// the IF/ID outputs. The fetch unit is the master side.
interface if_fetch_unit_if;

   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_npc;
   logic        ifid_valid;
   logic        halted;
   logic [31:0] fetch_count;

   modport master (
      input  stall, redirect_valid, redirect_target, mem_data,
      output mem_addr, ifid_instr, ifid_npc, ifid_valid, halted, fetch_count
   );

   modport slave (
      output stall, redirect_valid, redirect_target, mem_data,
      input  mem_addr, ifid_instr, ifid_npc, ifid_valid, halted, fetch_count
   );

endinterface

// File: rtl/if_fetch_unit_ifid_reg.sv
// IF/ID pipeline register. Priority: reset, bubble, load, otherwise hold.
module if_fetch_unit_ifid_reg #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_load,
   input  logic                    i_bubble,
   input  if_fetch_unit_pkg::ifid_t i_data,
   output if_fetch_unit_pkg::ifid_t o_q
);
   import if_fetch_unit_pkg::*;

   ifid_t r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= make_bubble(NOP_WORD);
      end else if (i_bubble) begin
         r_q <= make_bubble(NOP_WORD);
      end else if (i_load) begin
         r_q <= i_data;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage front half: program counter, next-PC selection, RUN/HALT FSM
// and fetch counter; captured words go into the IF/ID register.
module if_fetch_unit #(
   parameter int                   ADDR_W    = 7,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter logic [31:0]          HALT_WORD = if_fetch_unit_pkg::HALT_WORD,
   parameter logic [31:0]          NOP_WORD  = if_fetch_unit_pkg::NOP_WORD
) (
   input  logic          clk,
   input  logic          rst,
   if_fetch_unit_if.master bus
);
   import if_fetch_unit_pkg::*;

   logic [ADDR_W-1:0] r_pc;
   fetch_state_e      r_state;
   logic              r_halted;
   logic [31:0]       r_fetch_count;

   logic [ADDR_W-1:0] w_pc_inc;
   logic [31:0]       w_npc;
   logic              w_is_halt;
   logic              w_fetch;
   logic              w_bubble;
   ifid_t             w_ifid_d;
   ifid_t             w_ifid_q;
   logic [31-ADDR_W:0] w_unused_target_hi;

   // Increment stays ADDR_W bits wide so the top address wraps to zero.
   assign w_pc_inc  = r_pc + 1'b1;
   assign w_npc     = {{(32-ADDR_W){1'b0}}, w_pc_inc};
   assign w_is_halt = (bus.mem_data == HALT_WORD);
   assign w_unused_target_hi = bus.redirect_target[31:ADDR_W];

   assign w_fetch  = !bus.redirect_valid && !bus.stall && (r_state == ST_RUN);
   assign w_bubble = bus.redirect_valid ||
                     (!bus.stall && (r_state == ST_HALT));

   assign w_ifid_d.instr = bus.mem_data;
   assign w_ifid_d.npc   = w_npc;
   assign w_ifid_d.valid = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_state       <= ST_RUN;
         r_halted      <= 1'b0;
         r_fetch_count <= 32'h0;
      end else if (bus.redirect_valid) begin
         r_pc     <= bus.redirect_target[ADDR_W-1:0];
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
      end else if (!bus.stall) begin
         case (r_state)
            ST_RUN: begin
               r_fetch_count <= r_fetch_count + 32'h1;
               // The halt word still enters IF/ID; only the PC freezes.
               if (w_is_halt) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_pc <= w_pc_inc;
               end
            end
            ST_HALT: begin
               r_state  <= ST_HALT;
               r_halted <= 1'b1;
            end
            default: begin
               r_state  <= ST_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   if_fetch_unit_ifid_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_fetch),
      .i_bubble (w_bubble),
      .i_data   (w_ifid_d),
      .o_q      (w_ifid_q)
   );

   assign bus.mem_addr    = {{(32-ADDR_W){1'b0}}, r_pc};
   assign bus.ifid_instr  = w_ifid_q.instr;
   assign bus.ifid_npc    = w_ifid_q.npc;
   assign bus.ifid_valid  = w_ifid_q.valid;
   assign bus.halted      = r_halted;
   assign bus.fetch_count = r_fetch_count;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Upstream half of the IF stage: owns the program counter and drives the word address of the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles hazard stalls, branch/jump redirects with a single-slot flush, a halt word, and a fetch counter.

Parameters:
- ADDR_W, 7: PC width in words. Instruction memory depth is 2**ADDR_W, 128 words.
- RESET_PC, 0: PC value after reset, word index.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000: encoding inserted into IF/ID as a bubble.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold. Freezes PC and IF/ID.
- redirect_valid  input  1  branch/jump taken in a later stage.
- redirect_target  input  32  word-index target. Only bits [ADDR_W-1:0] are used.
- mem_addr  output  32  word address to instruction memory. Equals the zero-extended PC.
- mem_data  input  32  instruction word from memory. Combinational in the same cycle as mem_addr.
- ifid_instr  output  32  IF/ID instruction.
- ifid_npc  output  32  IF/ID next-PC (PC+1, wrapped, zero-extended).
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch FSM is in HALT.
- fetch_count  output  32  instructions accepted into IF/ID since reset.

Behaviour:
- Reset values, applied at the clock edge while rst=1:
  - pc=RESET_PC
  - ifid_instr=NOP_WORD, ifid_npc=0, ifid_valid=0
  - halted=0, fetch_count=0
  - state=RUN
- mem_addr is driven combinationally from the pc register at all times, including during reset.
- Latency: the word at address p appears on ifid_instr one edge after mem_addr=p.
- Per-edge priority: rst > redirect_valid > stall > normal fetch.
- FSM states are RUN and HALT. Per-edge actions:
  - Redirect (either state):
    - pc <= redirect_target[ADDR_W-1:0].
    - IF/ID gets a bubble (NOP_WORD, npc 0, valid 0).
    - state <= RUN; fetch_count unchanged.
    - Redirect overrides stall in the same cycle.
  - Stall, no redirect: pc, IF/ID, state and fetch_count all hold.
  - RUN, normal, mem_data != HALT_WORD:
    - IF/ID <= {mem_data, pc+1, valid=1}.
    - pc <= pc+1.
    - fetch_count+1.
  - RUN, normal, mem_data == HALT_WORD:
    - IF/ID <= {HALT_WORD, pc+1, valid=1}, so the halt word flows downstream.
    - pc holds; fetch_count+1; state <= HALT.
  - HALT, no redirect, no stall: pc holds, IF/ID gets a bubble, fetch_count holds.
- halted equals (state==HALT) and is registered.
- Arithmetic:
  - pc+1 is computed in ADDR_W bits, so the last address wraps to 0. With defaults, 127 -> 0.
  - ifid_npc is the zero-extended wrapped value.
  - fetch_count wraps modulo 2**32 with no saturation.
- Reset mid-operation: any pending stall, redirect or HALT is discarded and all reset values above apply at that edge.

Decomposition:
- Shared package holds:
  - the NOP_WORD and HALT_WORD constants;
  - the fetch-state enum {RUN, HALT};
  - the IF/ID bundle typedef {instr[31:0], npc[31:0], valid}, which the decode stage reuses.
- One natural sub-module: ifid_reg. It is the IF/ID pipeline register with load, hold and bubble controls and a synchronous reset.
- The PC, next-PC mux and FSM stay in if_fetch_unit.

Test Plan:
1. Reset then sequential fetch: memory holds words 0..3 = 0x11,0x22,0x33,0x44; rst high 2 cycles, then low. Required: mem_addr=0 during reset. On successive edges ifid_instr=0x11,0x22,0x33 with ifid_npc=1,2,3 and valid=1. fetch_count=3.
2. Stall: assert stall for 2 cycles while pc=2. Required: mem_addr stays 2, ifid_instr stays 0x22, fetch_count unchanged. The next edge after release loads 0x33.
3. Redirect with stall: at pc=3 assert redirect_valid=1, redirect_target=0x50 and stall=1 together. Required next edge: pc=0x50, ifid_valid=0, ifid_instr=0. The following edge fetches word 0x50.
4. Wrap-around: redirect to 127, where mem[127]=0xAB. Required: ifid_instr=0xAB, ifid_npc=0, and the next mem_addr=0.
5. Halt: mem[5]=HALT_WORD. Required:
   - Edge after pc=5: ifid_instr=HALT_WORD, valid=1, halted=1, pc stays 5.
   - Subsequent edges: ifid_valid=0.
   - A redirect to 0 clears halted and resumes fetch from 0.
6. Reset mid-HALT with a concurrent redirect: assert rst=1 and redirect_valid=1 together. Required: pc=RESET_PC, halted=0, fetch_count=0, ifid_valid=0.
